// File: rtl/snax_acc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snax_acc_ctrl_pkg
// Brief   : Shared types and helpers for the SNAX accelerator offload
//           controller: FSM state type, CSR map offsets, STATUS bit layout.
// Revision: 1.0 - initial release
// ============================================================================
package snax_acc_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } ctrl_state_e;

  // STATUS register bit positions
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_START_BIT = 1;

  // The control CSRs sit directly above the configuration block
  function automatic int csr_start_addr(input int num_csr);
    return num_csr;
  endfunction

  function automatic int csr_status_addr(input int num_csr);
    return num_csr + 1;
  endfunction

  function automatic int csr_perf_addr(input int num_csr);
    return num_csr + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snax_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : snax_acc_ctrl
// Brief   : Offload controller between a Snitch accelerator port and a SNAX
//           accelerator datapath. Decodes CSR requests, holds configuration
//           registers, sequences launch/run/done and returns one response
//           per accepted request through a single-entry response register.
// Revision: 1.0 - initial release
// ============================================================================
module snax_acc_ctrl
  import snax_acc_ctrl_pkg::*;
#(
  parameter int NumCsr       = 8,
  parameter int CsrAddrWidth = 5,
  parameter int DataWidth    = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Request channel from the core
  input  logic                    acc_qvalid_i,
  output logic                    acc_qready_o,
  input  logic [4:0]              acc_qid_i,
  input  logic                    acc_qwrite_i,
  input  logic [CsrAddrWidth-1:0] acc_qaddr_i,
  input  logic [31:0]             acc_qdata_i,
  // Response channel to the core
  output logic                    acc_pvalid_o,
  input  logic                    acc_pready_i,
  output logic [4:0]              acc_pid_o,
  output logic [DataWidth-1:0]    acc_pdata_o,
  output logic                    acc_perror_o,
  // Accelerator side
  output logic [NumCsr*32-1:0]    csr_o,
  output logic                    start_o,
  input  logic                    start_ready_i,
  input  logic                    done_i,
  output logic                    busy_o,
  output logic [31:0]             perf_cycles_o
);

  // CSR map boundaries expressed in the address width
  localparam logic [CsrAddrWidth-1:0] NUM_CSR_ADDR = CsrAddrWidth'(NumCsr);
  localparam logic [CsrAddrWidth-1:0] START_ADDR   = CsrAddrWidth'(csr_start_addr(NumCsr));
  localparam logic [CsrAddrWidth-1:0] STATUS_ADDR  = CsrAddrWidth'(csr_status_addr(NumCsr));
  localparam logic [CsrAddrWidth-1:0] PERF_ADDR    = CsrAddrWidth'(csr_perf_addr(NumCsr));

  ctrl_state_e                 state_q;
  ctrl_state_e                 state_d;
  logic [NumCsr-1:0][31:0]     csr_q;
  logic [31:0]                 perf_q;

  logic                        pvalid_q;
  logic [4:0]                  pid_q;
  logic [DataWidth-1:0]        pdata_q;
  logic                        perror_q;

  logic                        is_config;
  logic                        is_start;
  logic                        is_status;
  logic                        is_perf;
  logic                        is_unmapped;
  logic                        req_error;
  logic                        stall;
  logic                        accept;
  logic                        cfg_we;
  logic                        launch;
  logic [31:0]                 status_word;
  logic [31:0]                 rdata;
  logic [DataWidth-1:0]        resp_data;

  // Address decode of the incoming request
  assign is_config   = acc_qaddr_i < NUM_CSR_ADDR;
  assign is_start    = acc_qaddr_i == START_ADDR;
  assign is_status   = acc_qaddr_i == STATUS_ADDR;
  assign is_perf     = acc_qaddr_i == PERF_ADDR;
  assign is_unmapped = !(is_config || is_start || is_status || is_perf);

  // Errors: unmapped address, or a write to one of the read-only CSRs
  assign req_error = is_unmapped || (acc_qwrite_i && (is_status || is_perf));

  // Only error-free writes (CONFIG/START) wait for the accelerator to finish;
  // reads keep flowing so the core can poll STATUS while busy.
  assign stall  = busy_o && acc_qwrite_i && !req_error;

  assign acc_qready_o = (!pvalid_q || acc_pready_i) && !stall;
  assign accept       = acc_qvalid_i && acc_qready_o;
  assign cfg_we       = accept && acc_qwrite_i && is_config;
  assign launch       = (state_q == IDLE) && (state_d == LAUNCH);

  // Next-state and accelerator-facing outputs of the sequencing FSM
  always_comb begin
    state_d = state_q;
    start_o = 1'b0;
    busy_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && acc_qwrite_i && is_start) state_d = LAUNCH;
      end
      LAUNCH: begin
        start_o = 1'b1;
        busy_o  = 1'b1;
        if (start_ready_i) state_d = RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register; reset drops start_o without waiting for a clock
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Configuration register file, written only by accepted CONFIG writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr_q <= '0;
    end else begin
      for (int k = 0; k < NumCsr; k++) begin
        if (cfg_we && (acc_qaddr_i == CsrAddrWidth'(k))) csr_q[k] <= acc_qdata_i;
      end
    end
  end

  assign csr_o = csr_q;

  // RUN-cycle counter: cleared at launch, saturating, held while idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (launch) begin
      perf_q <= '0;
    end else if ((state_q == RUN) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;

  // STATUS word assembled from the live controller state
  always_comb begin
    status_word                   = '0;
    status_word[STATUS_BUSY_BIT]  = busy_o;
    status_word[STATUS_START_BIT] = start_o;
  end

  // Read data mux; START and unmapped addresses read as zero
  always_comb begin
    rdata = '0;
    if (is_config) begin
      for (int k = 0; k < NumCsr; k++) begin
        if (acc_qaddr_i == CsrAddrWidth'(k)) rdata = csr_q[k];
      end
    end else if (is_status) begin
      rdata = status_word;
    end else if (is_perf) begin
      rdata = perf_q;
    end
  end

  assign resp_data = (acc_qwrite_i || req_error) ? '0 : DataWidth'(rdata);

  // Single-entry response register with back-to-back reload
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pvalid_q <= 1'b0;
      pid_q    <= '0;
      pdata_q  <= '0;
      perror_q <= 1'b0;
    end else if (accept) begin
      pvalid_q <= 1'b1;
      pid_q    <= acc_qid_i;
      pdata_q  <= resp_data;
      perror_q <= req_error;
    end else if (pvalid_q && acc_pready_i) begin
      pvalid_q <= 1'b0;
    end
  end

  assign acc_pvalid_o = pvalid_q;
  assign acc_pid_o    = pid_q;
  assign acc_pdata_o  = pdata_q;
  assign acc_perror_o = perror_q;

endmodule
`default_nettype wire

// File: tb/tb_snax_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_snax_acc_ctrl
// Brief   : Self-checking bench for snax_acc_ctrl: directed scenarios plus
//           randomized traffic against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_snax_acc_ctrl;

  localparam int NUM_CSR = 8;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 64;

  localparam int PH_IDLE   = 0;
  localparam int PH_LAUNCH = 1;
  localparam int PH_RUN    = 2;

  logic                  clk;
  logic                  rst;
  logic                  acc_qvalid;
  logic                  acc_qready;
  logic [4:0]            acc_qid;
  logic                  acc_qwrite;
  logic [ADDR_W-1:0]     acc_qaddr;
  logic [31:0]           acc_qdata;
  logic                  acc_pvalid;
  logic                  acc_pready;
  logic [4:0]            acc_pid;
  logic [DATA_W-1:0]     acc_pdata;
  logic                  acc_perror;
  logic [NUM_CSR*32-1:0] csr;
  logic                  start;
  logic                  start_ready;
  logic                  done;
  logic                  busy;
  logic [31:0]           perf_cycles;

  snax_acc_ctrl #(
    .NumCsr      (NUM_CSR),
    .CsrAddrWidth(ADDR_W),
    .DataWidth   (DATA_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .acc_qvalid_i (acc_qvalid),
    .acc_qready_o (acc_qready),
    .acc_qid_i    (acc_qid),
    .acc_qwrite_i (acc_qwrite),
    .acc_qaddr_i  (acc_qaddr),
    .acc_qdata_i  (acc_qdata),
    .acc_pvalid_o (acc_pvalid),
    .acc_pready_i (acc_pready),
    .acc_pid_o    (acc_pid),
    .acc_pdata_o  (acc_pdata),
    .acc_perror_o (acc_perror),
    .csr_o        (csr),
    .start_o      (start),
    .start_ready_i(start_ready),
    .done_i       (done),
    .busy_o       (busy),
    .perf_cycles_o(perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  typedef struct {
    logic [4:0]  id;
    logic [63:0] data;
    logic        err;
  } resp_t;

  resp_t       mq[$];
  bit [31:0]   m_csr[NUM_CSR];
  bit [31:0]   m_perf;
  int          m_phase;

  int checks;
  int failures;
  int start_hi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NUM_CSR; k++) m_csr[k] = '0;
    m_perf  = '0;
    m_phase = PH_IDLE;
  endtask

  task automatic idle_in();
    acc_qvalid  = 1'b0;
    acc_qwrite  = 1'b0;
    acc_qaddr   = '0;
    acc_qid     = '0;
    acc_qdata   = '0;
    start_ready = 1'b0;
    done        = 1'b0;
  endtask

  task automatic set_req(input bit wr, input int addr, input int id, input logic [31:0] data);
    acc_qvalid = 1'b1;
    acc_qwrite = wr;
    acc_qaddr  = ADDR_W'(addr);
    acc_qid    = 5'(id);
    acc_qdata  = data;
  endtask

  // One clock cycle: compare DUT against the model at the falling edge using
  // the inputs currently applied, then advance the model past the rising edge.
  task automatic cycle();
    int        a;
    bit        busy_m, start_m, bad, err, stall_m, qrdy, acc;
    resp_t     r;
    bit [31:0] rd;
    @(negedge clk);
    busy_m  = (m_phase != PH_IDLE);
    start_m = (m_phase == PH_LAUNCH);
    if (start) start_hi++;
    check("start", start, start_m);
    check("busy", busy, busy_m);
    check("perf", perf_cycles, m_perf);
    for (int k = 0; k < NUM_CSR; k++) check($sformatf("csr%0d", k), csr[32*k +: 32], m_csr[k]);
    check("pvalid", acc_pvalid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("pid", acc_pid, mq[0].id);
      check("pdata", acc_pdata, mq[0].data);
      check("perror", acc_perror, mq[0].err);
    end

    a       = int'(acc_qaddr);
    bad     = a > NUM_CSR + 2;
    err     = bad || (acc_qwrite && a >= NUM_CSR + 1);
    stall_m = busy_m && acc_qwrite && !err;
    qrdy    = (mq.size() == 0 || acc_pready) && !stall_m;
    check("qready", acc_qready, qrdy);
    acc = acc_qvalid && qrdy;

    if (mq.size() != 0 && acc_pready) void'(mq.pop_front());
    if (acc) begin
      rd = '0;
      if (!acc_qwrite && !err) begin
        if (a < NUM_CSR)           rd = m_csr[a];
        else if (a == NUM_CSR + 1) rd = {30'd0, start_m, busy_m};
        else if (a == NUM_CSR + 2) rd = m_perf;
      end
      r.id   = acc_qid;
      r.data = {32'd0, rd};
      r.err  = err;
      mq.push_back(r);
    end

    if (m_phase == PH_RUN) begin
      if (m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
      if (done) m_phase = PH_IDLE;
    end else if (m_phase == PH_LAUNCH) begin
      if (start_ready) m_phase = PH_RUN;
    end
    if (acc && acc_qwrite && !err) begin
      if (a < NUM_CSR) m_csr[a] = acc_qdata;
      else begin
        m_phase = PH_LAUNCH;
        m_perf  = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    start_hi = 0;
    rst        = 1'b1;
    acc_pready = 1'b1;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pvalid", acc_pvalid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_csr", csr[63:0], 64'd0);
    rst = 1'b0;
    cycle();

    // Read CSR 0 with id 3
    set_req(0, 0, 3, 32'd0);
    cycle();
    idle_in();
    check("rd0_pvalid", acc_pvalid, 1'b1);
    check("rd0_pid", acc_pid, 5'd3);
    check("rd0_pdata", acc_pdata, 64'd0);
    check("rd0_perror", acc_perror, 1'b0);
    cycle();

    // Write then read CSR 2
    set_req(1, 2, 1, 32'hDEAD_BEEF);
    cycle();
    idle_in();
    check("wr2_csr", csr[95:64], 32'hDEAD_BEEF);
    set_req(0, 2, 2, 32'd0);
    cycle();
    idle_in();
    check("rd2_pdata", acc_pdata, 64'h0000_0000_DEAD_BEEF);
    cycle();

    // START, delayed start_ready, done 10 cycles after the handshake
    start_hi = 0;
    set_req(1, NUM_CSR, 4, 32'd0);
    cycle();
    idle_in();
    repeat (3) cycle();
    start_ready = 1'b1;
    cycle();
    start_ready = 1'b0;
    check("start_hi_cycles", start_hi, 4);
    check("run_start", start, 1'b0);
    check("run_busy", busy, 1'b1);
    set_req(0, NUM_CSR + 1, 5, 32'd0);
    cycle();
    check("status_pid", acc_pid, 5'd5);
    check("status_pdata", acc_pdata, 64'd1);
    set_req(1, 1, 6, 32'h1234_5678);
    #1;
    check("stall_qready", acc_qready, 1'b0);
    repeat (8) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    check("post_done_busy", busy, 1'b0);
    check("post_done_perf", perf_cycles, 32'd10);
    check("post_done_qready", acc_qready, 1'b1);
    cycle();
    idle_in();
    check("stalled_cfg_csr", csr[63:32], 32'h1234_5678);
    set_req(0, NUM_CSR + 2, 8, 32'd0);
    cycle();
    idle_in();
    check("perf_pdata", acc_pdata, 64'd10);

    // Error responses
    set_req(0, NUM_CSR + 5, 10, 32'd0);
    cycle();
    check("unmapped_perror", acc_perror, 1'b1);
    check("unmapped_pdata", acc_pdata, 64'd0);
    set_req(1, NUM_CSR + 1, 11, 32'hFFFF_FFFF);
    cycle();
    idle_in();
    check("ro_wr_perror", acc_perror, 1'b1);
    check("ro_wr_busy", busy, 1'b0);
    cycle();

    // Response backpressure with two requests queued
    acc_pready = 1'b0;
    set_req(0, 2, 7, 32'd0);
    cycle();
    set_req(0, 0, 9, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_qready", acc_qready, 1'b0);
      cycle();
      check("bp_pid", acc_pid, 5'd7);
      check("bp_pdata", acc_pdata, 64'h0000_0000_DEAD_BEEF);
    end
    acc_pready = 1'b1;
    cycle();
    idle_in();
    check("bp_second_pvalid", acc_pvalid, 1'b1);
    check("bp_second_pid", acc_pid, 5'd9);
    cycle();

    // Reset in the middle of a launch
    set_req(1, NUM_CSR, 12, 32'd0);
    cycle();
    idle_in();
    check("pre_rst_start", start, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_start", start, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_pvalid", acc_pvalid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      acc_qvalid  = ($urandom_range(0, 3) != 0);
      acc_qwrite  = $urandom_range(0, 1) == 1;
      acc_qaddr   = ($urandom_range(0, 15) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, NUM_CSR + 3));
      acc_qid     = 5'($urandom);
      acc_qdata   = $urandom;
      acc_pready  = ($urandom_range(0, 3) != 0);
      start_ready = ($urandom_range(0, 2) == 0);
      done        = ($urandom_range(0, 6) == 0);
      cycle();
    end
    idle_in();
    acc_pready = 1'b1;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
